// File: rtl/minterm_sweep_ctrl.sv
// Steps a function's inputs through every minterm in ascending order, samples F after a
// programmable settle time, and compares the captured truth table against an expected mask.
module minterm_sweep_ctrl #(
   parameter int N_VARS = 4,
   parameter int SETTLE = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   input  logic [2**N_VARS-1:0]   expected,
   output logic [N_VARS-1:0]      vars_out,
   input  logic                   f_in,
   output logic                   busy,
   output logic                   done,
   output logic [2**N_VARS-1:0]   truth_table,
   output logic [N_VARS:0]        mismatch_cnt,
   output logic [N_VARS-1:0]      first_mismatch,
   output logic                   mismatch_any
);

   localparam logic [N_VARS-1:0] LAST_MINTERM = '1;
   localparam logic [3:0]        SETTLE_LAST  = 4'(SETTLE - 1);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t                 state_reg;
   logic [2**N_VARS-1:0]   expected_reg;
   logic [N_VARS-1:0]      vars_reg;
   logic [3:0]             settle_cnt_reg;
   logic                   busy_reg;
   logic                   done_reg;
   logic [2**N_VARS-1:0]   truth_table_reg;
   logic [N_VARS:0]        mismatch_cnt_reg;
   logic [N_VARS-1:0]      first_mismatch_reg;
   logic                   mismatch_any_reg;

   // vars_reg doubles as the minterm index; it is held at 0 whenever idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg          <= ST_IDLE;
         expected_reg       <= '0;
         vars_reg           <= '0;
         settle_cnt_reg     <= '0;
         busy_reg           <= 1'b0;
         done_reg           <= 1'b0;
         truth_table_reg    <= '0;
         mismatch_cnt_reg   <= '0;
         first_mismatch_reg <= '0;
         mismatch_any_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  expected_reg       <= expected;
                  truth_table_reg    <= '0;
                  mismatch_cnt_reg   <= '0;
                  first_mismatch_reg <= '0;
                  mismatch_any_reg   <= 1'b0;
                  vars_reg           <= '0;
                  settle_cnt_reg     <= '0;
                  busy_reg           <= 1'b1;
                  state_reg          <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (abort) begin
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
                  vars_reg  <= '0;
               end else if (settle_cnt_reg == SETTLE_LAST) begin
                  truth_table_reg[vars_reg] <= f_in;
                  if (f_in != expected_reg[vars_reg]) begin
                     mismatch_cnt_reg <= mismatch_cnt_reg + 1'b1;
                     mismatch_any_reg <= 1'b1;
                     // Only the lowest mismatching minterm is kept, since the sweep ascends.
                     if (!mismatch_any_reg)
                        first_mismatch_reg <= vars_reg;
                  end
                  if (vars_reg == LAST_MINTERM) begin
                     state_reg <= ST_IDLE;
                     busy_reg  <= 1'b0;
                     vars_reg  <= '0;
                     done_reg  <= 1'b1;
                  end else begin
                     vars_reg       <= vars_reg + 1'b1;
                     settle_cnt_reg <= '0;
                  end
               end else begin
                  settle_cnt_reg <= settle_cnt_reg + 4'd1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign vars_out       = vars_reg;
   assign busy           = busy_reg;
   assign done           = done_reg;
   assign truth_table    = truth_table_reg;
   assign mismatch_cnt   = mismatch_cnt_reg;
   assign first_mismatch = first_mismatch_reg;
   assign mismatch_any   = mismatch_any_reg;

endmodule

// File: tb/tb_minterm_sweep_ctrl.sv
// Directed bench for minterm_sweep_ctrl: one instance at SETTLE=1, one at SETTLE=3,
// both driving the F = B'CD' + BC' + A'D + A'C function.
module tb_minterm_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start1, abort1, start3, abort3;
   logic        force1;
   logic [15:0] expected;

   logic [3:0]  vars1, vars3;
   logic        f1, f3;
   logic        busy1, done1, busy3, done3;
   logic [15:0] tt1, tt3;
   logic [4:0]  cnt1, cnt3;
   logic [3:0]  first1, first3;
   logic        any1, any3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   function automatic logic f_sop(input logic [3:0] v);
      logic a, b, c, d;
      {a, b, c, d} = v;
      return (!b & c & !d) | (b & !c) | (!a & d) | (!a & c);
   endfunction

   assign f1 = force1 | f_sop(vars1);
   assign f3 = f_sop(vars3);

   minterm_sweep_ctrl #(.N_VARS(4), .SETTLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .expected(expected),
      .vars_out(vars1), .f_in(f1), .busy(busy1), .done(done1), .truth_table(tt1),
      .mismatch_cnt(cnt1), .first_mismatch(first1), .mismatch_any(any1)
   );

   minterm_sweep_ctrl #(.N_VARS(4), .SETTLE(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .expected(expected),
      .vars_out(vars3), .f_in(f3), .busy(busy3), .done(done3), .truth_table(tt3),
      .mismatch_cnt(cnt3), .first_mismatch(first3), .mismatch_any(any3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full SETTLE=1 sweep on dut1; returns one cycle after done.
   task automatic sweep1(input logic [15:0] exp_tt);
      expected = exp_tt;
      start1   = 1'b1;
      tick();
      start1   = 1'b0;
      chk("s1_busy_rise", busy1, 1);
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("s1_vars_%0d", k), vars1, k);
         chk($sformatf("s1_nodone_%0d", k), done1, 0);
         tick();
      end
      chk("s1_done", done1, 1);
      chk("s1_busy_fall", busy1, 0);
      chk("s1_vars_idle", vars1, 0);
      tick();
      chk("s1_done_single", done1, 0);
   endtask

   initial begin
      rst_n = 1'b0; start1 = 0; abort1 = 0; start3 = 0; abort3 = 0;
      force1 = 0; expected = 16'h0000;
      #3;
      chk("rst_busy", busy1, 0);
      chk("rst_done", done1, 0);
      chk("rst_vars", vars1, 0);
      chk("rst_tt", tt1, 0);
      chk("rst_cnt", cnt1, 0);
      chk("rst_any", any1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      $display("txn 1: netlist, expected=34FE");
      sweep1(16'h34FE);
      chk("t1_tt", tt1, 16'h34FE);
      chk("t1_cnt", cnt1, 0);
      chk("t1_any", any1, 0);
      chk("t1_first", first1, 0);

      $display("txn 2: netlist, expected=34FF");
      sweep1(16'h34FF);
      chk("t2_tt", tt1, 16'h34FE);
      chk("t2_cnt", cnt1, 1);
      chk("t2_first", first1, 0);
      chk("t2_any", any1, 1);

      $display("txn 3: f_in=1, expected=0000 then FFF7");
      force1 = 1'b1;
      sweep1(16'h0000);
      chk("t3a_tt", tt1, 16'hFFFF);
      chk("t3a_cnt", cnt1, 16);
      chk("t3a_first", first1, 0);
      chk("t3a_any", any1, 1);
      sweep1(16'hFFF7);
      chk("t3b_cnt", cnt1, 1);
      chk("t3b_first", first1, 3);
      force1 = 1'b0;

      $display("txn 4: SETTLE=3 sweep with mid-sweep start");
      expected = 16'h34FE;
      start3   = 1'b1;
      tick();
      start3   = 1'b0;
      chk("t4_busy", busy3, 1);
      for (int k = 0; k < 48; k++) begin
         chk($sformatf("t4_vars_%0d", k), vars3, k / 3);
         chk($sformatf("t4_nodone_%0d", k), done3, 0);
         start3 = (k == 20);
         tick();
      end
      start3 = 1'b0;
      chk("t4_done", done3, 1);
      chk("t4_busy_fall", busy3, 0);
      chk("t4_tt", tt3, 16'h34FE);
      chk("t4_cnt", cnt3, 0);
      tick();
      chk("t4_done_single", done3, 0);
      chk("t4_busy_idle", busy3, 0);

      $display("txn 5: abort at edge 5");
      force1   = 1'b1;
      expected = 16'h0000;
      start1   = 1'b1;
      tick();                       // edge 0
      start1   = 1'b0;
      for (int k = 1; k <= 4; k++) tick();
      abort1 = 1'b1;
      tick();                       // edge 5
      abort1 = 1'b0;
      chk("t5_busy", busy1, 0);
      chk("t5_vars", vars1, 0);
      chk("t5_done", done1, 0);
      chk("t5_tt", tt1, 16'h000F);
      chk("t5_cnt", cnt1, 4);
      tick();
      chk("t5_done_later", done1, 0);
      force1 = 1'b0;
      sweep1(16'h34FE);
      chk("t5_clean_tt", tt1, 16'h34FE);
      chk("t5_clean_cnt", cnt1, 0);

      $display("txn 6: reset at edge 7");
      expected = 16'h34FE;
      start1   = 1'b1;
      tick();                       // edge 0
      start1   = 1'b0;
      for (int k = 1; k <= 7; k++) tick();
      chk("t6_pre_tt", tt1, 16'h007E);
      chk("t6_pre_vars", vars1, 7);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_busy", busy1, 0);
      chk("t6_vars", vars1, 0);
      chk("t6_tt", tt1, 0);
      chk("t6_done", done1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("t6_idle_done", done1, 0);
      sweep1(16'h34FE);
      chk("t6_after_tt", tt1, 16'h34FE);
      chk("t6_after_any", any1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/minterm_sweep_ctrl.md
# minterm_sweep_ctrl

Sequencer that exhaustively exercises one generated sum-of-products logic function, such as F = B'CD' + BC' + A'D + A'C. It drives the function's inputs through all 2^N_VARS minterms in ascending order and samples F after a programmable settle time. The sampled values are assembled into a truth table and checked against an expected minterm mask. It sits between the minimized-function netlist and the self-check/reporting logic, and is the standard harness for on-chip validation of minimizer output.

## Interface
- N_VARS, 4, number of function inputs; minterm index width.
- SETTLE, 1, cycles from a vars_out change to the f_in sample; legal range 1..15.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  sweep request; accepted only in IDLE.
- abort  in  1  synchronous sweep cancel; effective only while busy.
- expected  in  2^N_VARS  expected truth table, bit i = F(minterm i); latched on start acceptance.
- vars_out  out  N_VARS  function inputs, MSB = A … LSB = D for N_VARS=4.
- f_in  in  1  function output under test.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle completion pulse.
- truth_table  out  2^N_VARS  captured F values, bit i = sample at minterm i.
- mismatch_cnt  out  N_VARS+1  count of bits where truth_table ≠ expected.
- first_mismatch  out  N_VARS  lowest mismatching minterm index; 0 if none.
- mismatch_any  out  1  mismatch_cnt ≠ 0.

## Operation
- States: IDLE, WAIT.
- IDLE, start=1 at the accepting edge:
  - latch expected;
  - clear truth_table, mismatch_cnt, first_mismatch, mismatch_any;
  - set idx=0, vars_out=0, settle_cnt=0, busy=1;
  - go to WAIT.
- WAIT, each edge:
  - If abort=1: go to IDLE, busy=0, vars_out=0, no done pulse. Results keep their partial values.
  - Else if settle_cnt==SETTLE-1: truth_table[idx] ← f_in.
    - If f_in ≠ expected_q[idx]: increment mismatch_cnt and set mismatch_any. If this is the first mismatch of the sweep, first_mismatch ← idx.
    - If idx==2^N_VARS-1: go to IDLE, busy=0, vars_out=0, done=1 for the next cycle only.
    - Otherwise: idx+1, vars_out ← idx+1, settle_cnt=0.
  - Else: settle_cnt+1.
- start while busy: ignored. start together with abort in IDLE: start accepted, abort ignored.
- start asserted in the cycle where done=1: accepted normally.
- Changes on expected during a sweep: ignored.
- Results hold until the next accepted start.
- mismatch_cnt cannot overflow; its maximum value is 2^N_VARS.

## Timing
- Reset values of all outputs are 0; all internal state is 0; FSM is in IDLE. Reset asserted mid-sweep takes effect immediately (asynchronous) and aborts the sweep without a done pulse.
- Each minterm is presented for exactly SETTLE cycles. f_in is sampled at the SETTLE-th rising edge after vars_out changes.
- Let the start-acceptance edge be edge 0:
  - the sample for minterm i occurs at edge (i+1)·SETTLE;
  - the completion edge is 2^N_VARS·SETTLE;
  - done is high for the single cycle following the completion edge.
- busy rises after edge 0 and falls after the completion or abort edge.
- Abort latency is 1 edge. vars_out is 0 from the following cycle.
- Outputs are registered. f_in is treated as combinational from vars_out and must settle within SETTLE cycles.

## Test plan
- Connect the F = B'CD' + BC' + A'D + A'C netlist; SETTLE=1, expected=16'h34FE, pulse start → vars_out steps 0..15 one cycle each; done at the cycle after edge 16; truth_table=16'h34FE; mismatch_cnt=0; mismatch_any=0.
- Same netlist, expected=16'h34FF → truth_table=16'h34FE, mismatch_cnt=1, first_mismatch=0, mismatch_any=1.
- f_in tied 1, expected=16'h0000 → truth_table=16'hFFFF, mismatch_cnt=16, first_mismatch=0. Then expected=16'hFFF7 → mismatch_cnt=1, first_mismatch=3.
- SETTLE=3 with the netlist → each vars_out value held 3 cycles; samples at edges 3,6,…,48; done after edge 48; start pulsed mid-sweep has no effect.
- abort asserted at edge 5, SETTLE=1 → busy=0 and vars_out=0 next cycle; no done pulse; truth_table bits 0..3 captured. A following start runs a full clean sweep.
- rst_n driven low at edge 7 mid-sweep → all outputs 0 immediately without waiting for a clock; after release, start yields a normal sweep.
